freqdiv_ratio_ctrl: RTL and testbench

Run-time ratio controller for the `frequency_divider` block. It accepts divide-ratio change requests over a valid/ready handshake and range-checks them. It drives the divider's `reset` and `mc` inputs so a new ratio is applied only at a count wrap, then reports lock once the new period has settled. It sits between the configuration master and one `frequency_divider` instance, and is the only driver of that instance's `reset` and `mc`.

---
 rtl/freqdiv_pkg.sv | 29 ++
 rtl/freqdiv_ratio_ctrl_if.sv | 34 +++
 rtl/freqdiv_cycle_timer.sv | 26 ++
 rtl/freqdiv_ratio_ctrl.sv | 173 +++++++++++++++++
 tb/tb_freqdiv_ratio_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/freqdiv_pkg.sv
// Shared types and constants for the frequency-divider ratio controller.
package freqdiv_pkg;

  // Width of a divide ratio and of the divider's mc/count buses.
  localparam int FD_RATIO_W = 4;

  // Width of the shared watchdog/settle timer.
  localparam int FD_TIMER_W = 5;

  // Legal ratio window; the upper bound is limited by the 4-bit mc bus.
  localparam int FD_MIN_RATIO = 2;
  localparam int FD_MAX_RATIO = 15;

  // Controller states, in the order a ratio change walks through them.
  typedef enum logic [2:0] {
    ST_BOOT      = 3'd0,
    ST_IDLE      = 3'd1,
    ST_WAIT_WRAP = 3'd2,
    ST_RELOAD    = 3'd3,
    ST_SETTLE    = 3'd4
  } freqdiv_ctrl_state_t;

  // True when a requested ratio lies inside [lo, hi].
  function automatic logic ratio_legal(input logic [FD_RATIO_W-1:0] r,
                                       input int lo, input int hi);
    return (int'(r) >= lo) && (int'(r) <= hi);
  endfunction

endpackage

// File: rtl/freqdiv_ratio_ctrl_if.sv
// Ratio-change request/response bundle between the configuration master and
// the ratio controller.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; req_ratio must be stable while req_valid is high.
// The master may hold req_valid high across cycles. resp_valid is a one-cycle
// completion pulse with no back-pressure; resp_err is meaningful only while
// resp_valid is high.
interface freqdiv_ratio_ctrl_if;
  import freqdiv_pkg::*;

  logic                  req_valid;
  logic [FD_RATIO_W-1:0] req_ratio;
  logic                  req_ready;
  logic                  resp_valid;
  logic                  resp_err;

  modport master (
    output req_valid,
    output req_ratio,
    input  req_ready,
    input  resp_valid,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_ratio,
    output req_ready,
    output resp_valid,
    output resp_err
  );

endinterface

// File: rtl/freqdiv_cycle_timer.sv
// Saturating up-counter with synchronous clear. One instance serves both the
// WAIT_WRAP watchdog and the SETTLE edge count, since those never overlap.
module freqdiv_cycle_timer
  import freqdiv_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  en,
  output logic [FD_TIMER_W-1:0] count
);

  localparam logic [FD_TIMER_W-1:0] CNT_MAX = '1;

  // Clear wins over count; the counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + FD_TIMER_W'(1);
    end
  end

endmodule

// File: rtl/freqdiv_ratio_ctrl.sv
// Run-time ratio controller for one frequency_divider instance. Accepts ratio
// change requests, range-checks them, applies a new ratio only at a count wrap
// (or after a watchdog timeout) by pulsing the divider reset, and reports lock
// once the new period has run for one full period.
module freqdiv_ratio_ctrl
  import freqdiv_pkg::*;
#(
  parameter int DEFAULT_RATIO = 6,
  parameter int MIN_RATIO     = FD_MIN_RATIO,
  parameter int MAX_RATIO     = FD_MAX_RATIO,
  parameter int WATCHDOG      = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  freqdiv_ratio_ctrl_if.slave   cfg,
  output logic                  div_reset,
  output logic [FD_RATIO_W-1:0] div_mc,
  input  logic [FD_RATIO_W-1:0] div_pos_count,
  output logic                  locked,
  output logic [FD_RATIO_W-1:0] cur_ratio,
  output freqdiv_ctrl_state_t   dbg_state
);

  localparam logic [FD_RATIO_W-1:0] DEF_RATIO = FD_RATIO_W'(DEFAULT_RATIO);
  localparam logic [FD_RATIO_W-1:0] DEF_MC    = FD_RATIO_W'(DEFAULT_RATIO - 1);
  localparam logic [FD_TIMER_W-1:0] WD_LAST   = FD_TIMER_W'(WATCHDOG - 1);

  freqdiv_ctrl_state_t state_q, state_d;

  // Ratio waiting to be applied at the next wrap.
  logic [FD_RATIO_W-1:0] pend_q, pend_d;
  // Set while SETTLE follows a RELOAD, so the completion pulse is owed;
  // clear for the boot settle, which is silent.
  logic                  from_reload_q, from_reload_d;

  // Next values of the registered outputs.
  logic                  req_ready_d;
  logic                  resp_valid_d;
  logic                  resp_err_d;
  logic                  div_reset_d;
  logic [FD_RATIO_W-1:0] div_mc_d;
  logic [FD_RATIO_W-1:0] cur_ratio_d;
  logic                  locked_d;

  logic [FD_TIMER_W-1:0] timer_q;
  logic                  timer_clr;
  logic                  timer_en;

  logic                  req_fire;
  logic                  req_ok;
  logic                  wrap_hit;
  logic                  wd_hit;
  logic                  settle_done;

  assign req_fire    = cfg.req_valid && cfg.req_ready;
  assign req_ok      = ratio_legal(cfg.req_ratio, MIN_RATIO, MAX_RATIO);
  // The divider sits at terminal count when its counter equals mc.
  assign wrap_hit    = (div_pos_count == div_mc);
  // timer_q counts edges already spent in the state, so the Nth edge sees N-1.
  assign wd_hit      = (timer_q == WD_LAST);
  assign settle_done = (timer_q == FD_TIMER_W'(div_mc));

  // The timer restarts on every state entry and only advances where it matters.
  assign timer_clr = (state_d != state_q);
  assign timer_en  = (state_q == ST_WAIT_WRAP) || (state_q == ST_SETTLE);

  assign dbg_state = state_q;

  freqdiv_cycle_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (timer_clr),
    .en    (timer_en),
    .count (timer_q)
  );

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    from_reload_d = from_reload_q;
    req_ready_d   = 1'b0;
    resp_valid_d  = 1'b0;
    resp_err_d    = 1'b0;
    div_reset_d   = 1'b0;
    div_mc_d      = div_mc;
    cur_ratio_d   = cur_ratio;
    locked_d      = 1'b0;

    case (state_q)
      ST_BOOT: begin
        // The reset-time div_reset already reloaded the divider.
        state_d       = ST_SETTLE;
        from_reload_d = 1'b0;
      end

      ST_IDLE: begin
        req_ready_d = 1'b1;
        locked_d    = 1'b1;
        if (req_fire) begin
          if (!req_ok) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (cfg.req_ratio == cur_ratio) begin
            resp_valid_d = 1'b1;
          end else begin
            pend_d      = cfg.req_ratio;
            state_d     = ST_WAIT_WRAP;
            req_ready_d = 1'b0;
            locked_d    = 1'b0;
          end
        end
      end

      ST_WAIT_WRAP: begin
        // A forced reload after the watchdog is a normal completion.
        if (wrap_hit || wd_hit) begin
          state_d     = ST_RELOAD;
          div_reset_d = 1'b1;
          div_mc_d    = pend_q - FD_RATIO_W'(1);
          cur_ratio_d = pend_q;
        end
      end

      ST_RELOAD: begin
        state_d       = ST_SETTLE;
        from_reload_d = 1'b1;
      end

      ST_SETTLE: begin
        if (settle_done) begin
          state_d       = ST_IDLE;
          req_ready_d   = 1'b1;
          locked_d      = 1'b1;
          resp_valid_d  = from_reload_q;
          from_reload_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State, request latch and output registers; reset restores boot values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_BOOT;
      pend_q         <= DEF_RATIO;
      from_reload_q  <= 1'b0;
      cfg.req_ready  <= 1'b0;
      cfg.resp_valid <= 1'b0;
      cfg.resp_err   <= 1'b0;
      div_reset      <= 1'b1;
      div_mc         <= DEF_MC;
      cur_ratio      <= DEF_RATIO;
      locked         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      from_reload_q  <= from_reload_d;
      cfg.req_ready  <= req_ready_d;
      cfg.resp_valid <= resp_valid_d;
      cfg.resp_err   <= resp_err_d;
      div_reset      <= div_reset_d;
      div_mc         <= div_mc_d;
      cur_ratio      <= cur_ratio_d;
      locked         <= locked_d;
    end
  end

endmodule

// File: tb/tb_freqdiv_ratio_ctrl.sv
// Bench for freqdiv_ratio_ctrl: directed boot/illegal/same/change/watchdog/
// mid-operation-reset cases plus a randomized request mix, with a behavioural
// divider counter and a response scoreboard.
module tb_freqdiv_ratio_ctrl;
  import freqdiv_pkg::*;

  localparam int DEF   = 6;
  localparam int MIN_R = 2;
  localparam int MAX_R = 15;
  localparam int WD    = 31;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial begin
    clk = 1'b0;
    #10;
    forever begin
      clk = 1'b1;
      #5;
      clk = 1'b0;
      #5;
    end
  end

  // Posedges since the last reset deassertion (edge 1 = first posedge).
  int edge_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  // ---------------- DUT ----------------
  logic                  req_valid;
  logic [3:0]            req_ratio;
  logic                  req_ready;
  logic                  resp_valid;
  logic                  resp_err;
  logic                  div_reset;
  logic [3:0]            div_mc;
  logic [3:0]            div_pos_count;
  logic                  locked;
  logic [3:0]            cur_ratio;
  freqdiv_ctrl_state_t   dbg_state;

  freqdiv_ratio_ctrl_if cfg_if ();
  assign cfg_if.req_valid = req_valid;
  assign cfg_if.req_ratio = req_ratio;
  assign req_ready        = cfg_if.req_ready;
  assign resp_valid       = cfg_if.resp_valid;
  assign resp_err         = cfg_if.resp_err;

  freqdiv_ratio_ctrl #(
    .DEFAULT_RATIO (DEF),
    .MIN_RATIO     (MIN_R),
    .MAX_RATIO     (MAX_R),
    .WATCHDOG      (WD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg           (cfg_if.slave),
    .div_reset     (div_reset),
    .div_mc        (div_mc),
    .div_pos_count (div_pos_count),
    .locked        (locked),
    .cur_ratio     (cur_ratio),
    .dbg_state     (dbg_state)
  );

  // Behavioural divider posedge counter: counts 0..mc, cleared by its reset.
  logic [3:0] pc_q;
  logic       hold_zero;
  always @(posedge clk or posedge reset) begin
    if (reset)                             pc_q <= 4'd0;
    else if (div_reset || (pc_q == div_mc)) pc_q <= 4'd0;
    else                                   pc_q <= pc_q + 4'd1;
  end
  assign div_pos_count = hold_zero ? 4'd0 : pc_q;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Entry: {legal_change, err, ratio_after}
  logic [5:0] exp_q[$];
  int         acc_q[$];

  // Reference model of the configuration and of the in-flight change.
  logic [3:0] model_ratio;
  logic       mon_en;
  logic       txn_active;
  int         txn_acc;
  logic [3:0] txn_old_mc;
  logic [3:0] txn_n;
  int         txn_w;

  // ---------------- monitor ----------------
  int         mon_e;
  logic [5:0] ent;
  int         acc_e;
  int         exp_e;
  logic       exp_dr;

  always @(negedge clk) begin
    if (!reset && mon_en) begin
      mon_e  = edge_cnt;
      exp_dr = txn_active && (txn_w == mon_e);

      // Divider reset appears exactly at the predicted reload edge.
      if (div_reset || exp_dr) begin
        check("reload_edge", int'(div_reset), int'(exp_dr));
        check("reload_cur_ratio", int'(cur_ratio), int'(txn_n));
        check("reload_div_mc", int'(div_mc), int'(txn_n) - 1);
      end

      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          ent   = exp_q.pop_front();
          acc_e = acc_q.pop_front();
          exp_e = ent[5] ? (txn_w + 1 + int'(ent[3:0])) : acc_e;
          check("resp_edge", mon_e, exp_e);
          check("resp_err", int'(resp_err), int'(ent[4]));
          check("resp_cur_ratio", int'(cur_ratio), int'(ent[3:0]));
          check("resp_div_mc", int'(div_mc), int'(ent[3:0]) - 1);
          check("resp_locked", int'(locked), 1);
          check("resp_ready", int'(req_ready), 1);
          if (ent[5]) txn_active = 1'b0;
        end
      end else if (txn_active && (mon_e >= txn_acc)) begin
        check("busy_ready", int'(req_ready), 0);
        check("busy_locked", int'(locked), 0);
      end else if (!txn_active) begin
        check("idle_locked", int'(locked), 1);
        check("idle_cur_ratio", int'(cur_ratio), int'(model_ratio));
        check("idle_div_mc", int'(div_mc), int'(model_ratio) - 1);
      end

      // Predict the reload edge: first edge after acceptance that samples
      // terminal count, or the watchdog limit, whichever comes first.
      if (txn_active && (txn_w == 0)) begin
        if ((div_pos_count == txn_old_mc) || (mon_e + 1 == txn_acc + WD))
          txn_w = mon_e + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at negedge+2; returns at negedge+2 one cycle after acceptance.
  task automatic send(input logic [3:0] r);
    int guard;
    guard = 0;
    while (!req_ready && guard < 300) begin
      @(negedge clk);
      #2;
      guard++;
    end
    if (!req_ready) begin
      check("send_ready_timeout", 0, 1);
      return;
    end
    req_valid = 1'b1;
    req_ratio = r;
    if ((int'(r) < MIN_R) || (int'(r) > MAX_R)) begin
      exp_q.push_back({1'b0, 1'b1, model_ratio});
      acc_q.push_back(edge_cnt + 1);
    end else if (r == model_ratio) begin
      exp_q.push_back({1'b0, 1'b0, model_ratio});
      acc_q.push_back(edge_cnt + 1);
    end else begin
      exp_q.push_back({1'b1, 1'b0, r});
      acc_q.push_back(edge_cnt + 1);
      txn_acc     = edge_cnt + 1;
      txn_old_mc  = model_ratio - 4'd1;
      txn_n       = r;
      txn_w       = 0;
      txn_active  = 1'b1;
      model_ratio = r;
    end
    @(negedge clk);
    #2;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (((exp_q.size() != 0) || txn_active) && guard < 300) begin
      @(negedge clk);
      #2;
      guard++;
    end
    check("wait_idle_timeout", int'((exp_q.size() != 0) || txn_active), 0);
  endtask

  // Walks edges 1..DEF+1 after reset deassertion (caller is before edge 1).
  task automatic boot_checks();
    for (int k = 1; k <= DEF + 1; k++) begin
      @(negedge clk);
      check("boot_div_reset", int'(div_reset), 0);
      check("boot_resp_valid", int'(resp_valid), 0);
      check("boot_div_mc", int'(div_mc), DEF - 1);
      check("boot_cur_ratio", int'(cur_ratio), DEF);
      check("boot_locked", int'(locked), (k >= DEF + 1) ? 1 : 0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_div_reset"}, int'(div_reset), 1);
    check({tag, "_div_mc"}, int'(div_mc), DEF - 1);
    check({tag, "_cur_ratio"}, int'(cur_ratio), DEF);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_req_ready"}, int'(req_ready), 0);
    check({tag, "_resp_valid"}, int'(resp_valid), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    logic [3:0] r;

    reset       = 1'b1;
    req_valid   = 1'b0;
    req_ratio   = 4'd0;
    hold_zero   = 1'b0;
    mon_en      = 1'b0;
    model_ratio = 4'(DEF);
    txn_active  = 1'b0;
    txn_acc     = 0;
    txn_old_mc  = 4'd0;
    txn_n       = 4'd0;
    txn_w       = 0;

    // Boot: reset values, release at 5 ns, lock at edge DEF+1.
    #2;
    check_reset_values("rst");
    #3;
    reset = 1'b0;
    #2;
    check("boot_hold_div_reset", int'(div_reset), 1);
    boot_checks();
    #2;
    mon_en = 1'b1;

    // Illegal ratios back-to-back, then same ratio.
    send(4'd1);
    send(4'd0);
    send(4'd6);
    wait_idle();

    // Legal change 6 -> 3 at a real wrap.
    send(4'd3);
    wait_idle();

    // Randomized request mix with idle gaps.
    for (int i = 0; i < 16; i++) begin
      r = 4'($urandom_range(0, 15));
      send(r);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        #2;
      end
    end
    wait_idle();

    // Watchdog: divider count frozen at 0, so only the timeout can reload.
    if (model_ratio == 4'd4) begin
      send(4'd7);
      wait_idle();
    end
    hold_zero = 1'b1;
    send(4'd4);
    wait_idle();
    hold_zero = 1'b0;

    // Reset in the middle of SETTLE during a 6 -> 9 change.
    if (model_ratio != 4'd6) begin
      send(4'd6);
      wait_idle();
    end
    send(4'd9);
    guard = 0;
    while (!div_reset && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("midrst_reload_seen", int'(div_reset), 1);
    @(negedge clk);
    #2;
    check("midrst_in_settle", int'(dbg_state == ST_SETTLE), 1);
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    acc_q.delete();
    txn_active  = 1'b0;
    model_ratio = 4'(DEF);
    @(negedge clk);
    reset = 1'b0;
    boot_checks();
    #2;
    mon_en = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #2;
    end

    // Normal operation resumes after the aborted change.
    send(4'd2);
    wait_idle();
    repeat (3) begin
      @(negedge clk);
      #2;
    end
    check("leftover_resp", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
